// File: rtl/alu_scheduler.sv
// Two-requester front end for a single ALU. Requests are arbitrated round-robin,
// captured, executed for a fixed latency and the response is held until accepted.

module alu (
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);
  logic [47:0] mant_prod;
  logic [9:0]  fexp;
  logic [31:0] fmul;
  logic        fsign;
  logic        unused_low_bits;

  // Single-precision multiply: denormals flush to zero, mantissa truncated,
  // overflow saturates to infinity.
  always_comb begin
    fsign     = a[31] ^ b[31];
    mant_prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    fexp      = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'b0, mant_prod[47]};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || fexp[9] || fexp == 10'd0) begin
      fmul = {fsign, 31'b0};
    end else if (fexp >= 10'd255) begin
      fmul = {fsign, 8'hff, 23'b0};
    end else begin
      fmul = {fsign, fexp[7:0], mant_prod[47] ? mant_prod[46:24] : mant_prod[45:23]};
    end
  end

  assign unused_low_bits = ^mant_prod[22:0];

  always_comb begin
    case (alu_op)
      4'd0:    result = a + b;
      4'd1:    result = a - b;
      4'd2:    result = a * b;
      4'd3:    result = a & b;
      4'd4:    result = a | b;
      4'd5:    result = fmul;
      4'd6:    result = a ^ b;
      4'd7:    result = a << b[4:0];
      4'd8:    result = a >> b[4:0];
      default: result = 32'd0;
    endcase
    zero = (result == 32'd0);
  end
endmodule

module alu_scheduler #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cap_op, cnt, sel_op;
  logic [31:0] cap_a, cap_b, sel_a, sel_b, alu_result;
  logic        cap_id, last_grant, grant_id, hs, illegal, alu_zero;

  // Handshake: a request transfers on a cycle where reqN_valid and reqN_ready are
  // both high; the response transfers on a cycle where rsp_valid and rsp_ready are.
  assign grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign sel_op   = grant_id ? req1_op : req0_op;
  assign sel_a    = grant_id ? req1_a  : req0_a;
  assign sel_b    = grant_id ? req1_b  : req0_b;
  assign hs       = req0_ready | req1_ready;
  assign illegal  = (cap_op > 4'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && !rst && req0_valid && !grant_id;
    req1_ready = (state == IDLE) && !rst && req1_valid && grant_id;
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_op     <= 4'd0;
      cap_a      <= 32'd0;
      cap_b      <= 32'd0;
      cap_id     <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (hs) begin
      cap_op     <= sel_op;
      cap_a      <= sel_a;
      cap_b      <= sel_b;
      cap_id     <= grant_id;
      last_grant <= grant_id;
      cnt        <= (sel_op == 4'd2 || sel_op == 4'd5) ? MUL_CNT : 4'd0;
    end else if (state == EXEC) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        rsp_result <= illegal ? 32'd0 : alu_result;
        rsp_zero   <= illegal | alu_zero;
        rsp_err    <= illegal;
        rsp_id     <= cap_id;
      end
    end
  end

  alu u_alu (
    .alu_op (cap_op),
    .a      (cap_a),
    .b      (cap_b),
    .result (alu_result),
    .zero   (alu_zero)
  );
endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: directed scenarios plus randomized traffic checked
// against an arithmetic reference model and an expected-response queue.

module tb_alu_scheduler;
  localparam int unsigned MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;

  int          cyc = 0;
  int          n_pass = 0;
  int          n_checks = 0;
  int          t_hs = 0;
  int          rsp_cyc = 0;
  logic [34:0] exp_q[$];   // {id, err, zero, result}

  alu_scheduler #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] int_to_float(input logic s, input logic [31:0] v);
    int p;
    logic [31:0] m;
    if (v == 32'd0) return {s, 31'b0};
    p = 0;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    m = v << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [31:0] float_to_int(input logic [31:0] f);
    logic [31:0] m;
    if (f[30:23] == 8'd0) return 32'd0;
    m = {8'd0, 1'b1, f[22:0]};
    return m >> (150 - int'(f[30:23]));
  endfunction

  // Operands of the float multiply are whole numbers, so the product is exact.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    return int_to_float(a[31] ^ b[31], float_to_int(a) * float_to_int(b));
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (op == 4'd2 || op == 4'd5) ? int'(MUL_LAT) : 1;
  endfunction

  function automatic logic [34:0] model(input logic id, input logic [3:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic err;
    err = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a * b;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = fmul_ref(a, b);
      4'd6: r = a ^ b;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      default: begin r = 32'd0; err = 1'b1; end
    endcase
    return {id, err, (r == 32'd0), r};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int port, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic issue(input int port, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bit got;
    got = 0;
    set_req(port, 1'b1, op, a, b);
    for (int i = 0; i < 30 && !got; i++) begin
      #1;
      if ((port == 0) ? req0_ready : req1_ready) got = 1;
      else @(negedge clk);
    end
    check("grant", 64'(got), 64'd1);
    t_hs = cyc;
    exp_q.push_back(model(1'(port), op, a, b));
    @(posedge clk);
    #1;
    // Scribble the operand lines: they must no longer matter.
    set_req(port, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
  endtask

  task automatic await_rsp(input int lat, input bit chk_busy);
    bit got;
    logic [34:0] exp;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
      else if (chk_busy) check("busy_in_exec", 64'(busy), 64'd1);
    end
    check("rsp_seen", 64'(got), 64'd1);
    rsp_cyc = cyc;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      exp = exp_q.pop_front();
      if (got) begin
        check("latency", 64'(cyc - t_hs), 64'(1 + lat));
        check("rsp_fields", {29'd0, rsp_id, rsp_err, rsp_zero, rsp_result}, {29'd0, exp});
        check("busy_in_resp", 64'(busy), 64'd1);
      end
    end
  endtask

  // Both ports held valid; grants must alternate starting with first_port.
  task automatic contention(input int n, input int first_port);
    int exp_port;
    bit got;
    exp_port = first_port;
    set_req(0, 1'b1, 4'd1, 32'd3, 32'd3);
    set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
    for (int k = 0; k < n; k++) begin
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
        #1;
        if (req0_ready || req1_ready) got = 1;
        else @(negedge clk);
      end
      check("contend_grant_seen", 64'(got), 64'd1);
      if (k > 0) check("regrant_delay", 64'(cyc - rsp_cyc), 64'd1);
      check("contend_grant", {62'd0, req1_ready, req0_ready},
            (exp_port == 0) ? 64'b01 : 64'b10);
      t_hs = cyc;
      if (exp_port == 0) exp_q.push_back(model(1'b0, 4'd1, 32'd3, 32'd3));
      else               exp_q.push_back(model(1'b1, 4'd0, 32'd1, 32'd1));
      await_rsp(1, 1'b1);
      exp_port = 1 - exp_port;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {53'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err, busy,
                4'd0}, 64'd0);
    check({tag, "_result"}, 64'(rsp_result), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int port, hold;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [34:0] snap;

    // Reset state with requests already pending.
    set_req(0, 1'b1, 4'd1, 32'd3, 32'd3);
    set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
    #3;
    check_reset_outputs("reset_state");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Port 0 wins first contention, then alternation.
    contention(4, 0);

    // Simple add.
    issue(0, 4'd0, 32'd5, 32'd7);
    await_rsp(1, 1'b1);
    check("add_result", 64'(rsp_result), 64'd12);
    @(negedge clk);
    check("idle_after_add", {62'd0, busy, rsp_valid}, 64'd0);

    // Float multiply: 2.0 * 3.0 = 6.0 after MUL_LAT exec cycles.
    issue(1, 4'd5, 32'h4000_0000, 32'h4040_0000);
    await_rsp(MUL_LAT, 1'b1);
    check("fmul_result", 64'(rsp_result), 64'h40C0_0000);
    @(negedge clk);
    check("idle_after_fmul", {62'd0, busy, rsp_valid}, 64'd0);

    // Illegal opcode.
    issue(0, 4'd15, 32'hDEAD_BEEF, 32'h1234_5678);
    await_rsp(1, 1'b1);
    @(negedge clk);

    // Response back-pressure with both requesters knocking.
    rsp_ready = 1'b0;
    issue(1, 4'd4, 32'h0000_00F0, 32'h0000_000F);
    await_rsp(1, 1'b1);
    snap = {rsp_id, rsp_err, rsp_zero, rsp_result};
    check("hold_snapshot", {29'd0, snap}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h0000_00FF});
    set_req(0, 1'b1, 4'd0, 32'd9, 32'd9);
    set_req(1, 1'b1, 4'd0, 32'd8, 32'd8);
    repeat (5) begin
      @(negedge clk);
      check("hold_rsp", {28'd0, rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_result},
            {28'd0, 1'b1, snap});
      check("hold_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_after_hold", {62'd0, busy, rsp_valid}, 64'd0);
    check("rsp_retained", 64'(rsp_result), 64'h0000_00FF);

    // Reset in the middle of a multi-cycle multiply on port 0.
    issue(0, 4'd2, 32'd1234, 32'd5678);
    #2;
    rst = 1'b1;
    req0_valid = 1'b1;
    #1;
    check_reset_outputs("mid_exec_reset");
    exp_q.delete();
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("no_rsp_after_reset", {62'd0, rsp_valid, busy}, 64'd0);
    end
    contention(2, 0);

    // Randomized traffic with occasional back-pressure.
    for (int it = 0; it < 40; it++) begin
      port = int'($urandom_range(0, 1));
      op   = 4'($urandom_range(0, 15));
      a    = $urandom;
      b    = $urandom;
      if (op == 4'd5) begin
        a = int_to_float(1'($urandom_range(0, 1)), $urandom_range(1, 1000));
        b = int_to_float(1'($urandom_range(0, 1)), $urandom_range(1, 1000));
      end else if ($urandom_range(0, 3) == 0) begin
        a = b;
      end
      hold = int'($urandom_range(0, 3));
      rsp_ready = (hold == 0);
      issue(port, op, a, b);
      await_rsp(lat_of(op), 1'b1);
      if (hold > 0) begin
        snap = {rsp_id, rsp_err, rsp_zero, rsp_result};
        repeat (hold) begin
          @(negedge clk);
          check("rand_hold", {28'd0, rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_result},
                {28'd0, 1'b1, snap});
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      check("rand_idle", {62'd0, busy, rsp_valid}, 64'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, meaning the number of EXEC cycles for opcodes 0010 and 0101 (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 holds an operation.
REQ-005 SHALL have port req0_ready, output, 1 bit: requester 0 is granted this cycle.
REQ-006 SHALL have ports req0_op (input, 4 bits, ALU opcode), req0_a (input, 32 bits, operand a) and req0_b (input, 32 bits, operand b).
REQ-007 SHALL have ports req1_valid, req1_ready, req1_op, req1_a and req1_b, identical in direction, width and meaning to the port-0 set, for requester 1.
REQ-008 SHALL have port rsp_valid, output, 1 bit: response held.
REQ-009 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-010 SHALL have ports rsp_id (output, 1 bit, originating requester), rsp_result (output, 32 bits, ALU result) and rsp_zero (output, 1 bit, ALU zero flag).
REQ-011 SHALL have port rsp_err, output, 1 bit: opcode was outside 0000..1000.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL instantiate one alu, with its a, b and alu_op driven only from internal capture registers, never directly from requester ports.
REQ-014 SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-015 In IDLE, SHALL assert req_ready combinationally only for the granted port, and only if that port's valid is high; the other port's ready stays 0.
REQ-016 Grant rule: one valid port is granted; with both valid, the port not equal to last_grant is granted.
REQ-017 On a valid&ready handshake, SHALL latch op, a, b and the port id, update last_grant, load a 4-bit counter with L-1, and go to EXEC.
REQ-018 L SHALL equal MUL_LAT for opcodes 0010 and 0101, and 1 for all other opcodes.
REQ-019 In EXEC, SHALL decrement the counter each cycle; at counter==0, SHALL register the alu result and zero into rsp_result/rsp_zero, set rsp_err and rsp_id, and go to RESP.
REQ-020 Latency: for a handshake in cycle t, rsp_valid SHALL first be high in cycle t+1+L (single-cycle ops: t+2).
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_id, rsp_result, rsp_zero and rsp_err SHALL be stable until the rsp_valid&rsp_ready cycle, after which the FSM returns to IDLE.
REQ-022 The next request SHALL be grantable in the first IDLE cycle after the response handshake.
REQ-023 SHALL hold req0_ready and req1_ready at 0 in EXEC and RESP; requester inputs that change without a handshake SHALL be ignored.
REQ-024 Opcodes 1001..1111 SHALL take one EXEC cycle and respond with rsp_result=0, rsp_zero=1, rsp_err=1; legal opcodes respond with rsp_err=0.
REQ-025 rsp_valid SHALL be 0 in IDLE and EXEC; rsp_* data SHALL keep its last value outside RESP.
REQ-026 A port whose valid drops before it is granted SHALL lose its turn with no side effects.

Reset
REQ-027 While rst=1, immediately and regardless of clk: state=IDLE, counter=0, last_grant=1 (so port 0 wins first contention), capture registers=0, and rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy and both req_ready=0.
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation; no response for it SHALL appear after release.

Verification
REQ-029 Port 0, op 0000, a=5, b=7, rsp_ready=1, handshake in cycle t -> rsp_valid in cycle t+2 with result=12, zero=0, id=0, err=0.
REQ-030 Right after reset, both ports valid (port 0: op 0001, 3-3; port 1: op 0000, 1+1) -> port 0 served first (result 0, zero=1), then port 1 (result 2), with grants alternating while both stay valid.
REQ-031 MUL_LAT=3, op 0101, a=0x40000000, b=0x40400000 -> rsp_valid in cycle t+4 with result=0x40C00000; busy high from t+1 until the response handshake.
REQ-032 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and all rsp_* fields constant, both req_ready=0 despite valid requests; IDLE follows the accepting cycle.
REQ-033 op 1111 -> response at t+2 with result=0, zero=1, err=1.
REQ-034 rst pulsed mid-EXEC of an op 0010 -> all outputs 0 asynchronously, no rsp_valid after release, and the next request is serviced normally with port 0 favored.
